// File: rtl/pat_seq_pkg.sv
// Shared types and helpers for the pattern-processor program sequencer.
// Holds the sequencer state encoding, fault codes, the decoded-op type and
// the strobe priority selector. Optional repeat support (PAT_SEQ_REPEAT_EN)
// uses RPT_W and OP_RPT from here.
package pat_seq_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;

  localparam int unsigned RPT_W = 4;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BF   = 3'd1,
    OP_BB   = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_RPT  = 3'd5
  } op_e;

  // Highest-priority strobe wins; a failed condition turns every op into none.
  function automatic op_e sel_op(input logic bf, input logic bb, input logic call,
                                 input logic ret, input logic rpt, input logic cond_pass);
    op_e op;
    op = OP_NONE;
    if (cond_pass) begin
      if (bf)        op = OP_BF;
      else if (bb)   op = OP_BB;
      else if (call) op = OP_CALL;
      else if (ret)  op = OP_RET;
      else if (rpt)  op = OP_RPT;
    end
    return op;
  endfunction

endpackage

// File: rtl/pat_call_stack.sv
// Hardware call/return LIFO for the sequencer.
// Ports: clk, rst_n (async active-low, clears depth only), push/pop/clr
// strobes, push_data in; top_c (combinational top entry), depth (registered),
// full_c/empty_c out. Entry contents are never reset.
module pat_call_stack #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned I_ADR_W     = 10,
  parameter int unsigned DEPTH_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               clr,
  input  logic [I_ADR_W-1:0] push_data,
  output logic [I_ADR_W-1:0] top_c,
  output logic [DEPTH_W-1:0] depth,
  output logic               full_c,
  output logic               empty_c
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [I_ADR_W-1:0] mem_q [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign full_c  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty_c = (depth_q == '0);
  assign depth   = depth_q;

  // Write slot is the current depth; top sits one below it.
  always_comb begin
    wr_en  = push && !full_c && !clr;
    wr_idx = IDX_W'(depth_q);
    rd_idx = IDX_W'(depth_q - DEPTH_W'(1));
    top_c  = mem_q[rd_idx];
  end

  // Depth bookkeeping; clr has priority, push and pop are never both set.
  always_comb begin
    depth_d = depth_q;
    if (clr)                   depth_d = '0;
    else if (push && !full_c)  depth_d = depth_q + DEPTH_W'(1);
    else if (pop && !empty_c)  depth_d = depth_q - DEPTH_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pat_seq.sv
// Program sequencer: PC register, conditional branch/call/return with a
// hardware call stack, stall, and a sticky fault state on stack misuse.
// Ports: clk, reset (async active-low), stall, op_bf/op_bb/op_call/op_return
// strobes, cond_pass, offset, clear_fault in; pc, depth, fault, fault_code
// out. With PAT_SEQ_REPEAT_EN defined, adds op_repeat in and rpt_active out.
module pat_seq import pat_seq_pkg::*; #(
  parameter int unsigned I_ADR_W     = 10,
  parameter int unsigned OFF_W       = 8,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned DEPTH_W     = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               op_bf,
  input  logic               op_bb,
  input  logic               op_call,
  input  logic               op_return,
  input  logic               cond_pass,
  input  logic [OFF_W-1:0]   offset,
  input  logic               clear_fault,
`ifdef PAT_SEQ_REPEAT_EN
  input  logic               op_repeat,
  output logic               rpt_active,
`endif
  output logic [I_ADR_W-1:0] pc,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault,
  output logic [1:0]         fault_code
);

  state_e             state_q, state_d;
  logic [I_ADR_W-1:0] pc_q, pc_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic               push, pop, clr;
  logic [I_ADR_W-1:0] top_c;
  logic               full_c, empty_c;
  logic [I_ADR_W-1:0] pc_inc_c, off_ext_c;
  logic               rpt_req_c;
  op_e                op_c;

`ifdef PAT_SEQ_REPEAT_EN
  logic [RPT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
  assign rpt_req_c  = op_repeat;
  assign rpt_active = (rpt_cnt_q != '0);
`else
  assign rpt_req_c  = 1'b0;
`endif

  assign pc_inc_c   = pc_q + I_ADR_W'(1);
  assign off_ext_c  = I_ADR_W'(offset);
  assign op_c       = sel_op(op_bf, op_bb, op_call, op_return, rpt_req_c, cond_pass);
  assign pc         = pc_q;
  assign fault      = (state_q == FAULT);
  assign fault_code = fault_code_q;

  pat_call_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .I_ADR_W     (I_ADR_W),
    .DEPTH_W     (DEPTH_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop),
    .clr       (clr),
    .push_data (pc_inc_c),
    .top_c     (top_c),
    .depth     (depth),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  // Next-state, PC datapath and stack control.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_code_d = fault_code_q;
    push         = 1'b0;
    pop          = 1'b0;
    clr          = 1'b0;
`ifdef PAT_SEQ_REPEAT_EN
    rpt_cnt_d    = rpt_cnt_q;
`endif
    case (state_q)
      RUN: begin
        if (!stall) begin
          case (op_c)
            OP_BF: begin
              pc_d = pc_q + off_ext_c;
`ifdef PAT_SEQ_REPEAT_EN
              rpt_cnt_d = '0;
`endif
            end
            OP_BB: begin
              pc_d = pc_q - off_ext_c;
`ifdef PAT_SEQ_REPEAT_EN
              rpt_cnt_d = '0;
`endif
            end
            OP_CALL: begin
              if (full_c) begin
                state_d      = FAULT;
                fault_code_d = FC_OVF;
              end else begin
                push = 1'b1;
                pc_d = pc_q + off_ext_c;
              end
`ifdef PAT_SEQ_REPEAT_EN
              rpt_cnt_d = '0;
`endif
            end
            OP_RET: begin
              if (empty_c) begin
                state_d      = FAULT;
                fault_code_d = FC_UNF;
              end else begin
                pop  = 1'b1;
                pc_d = top_c;
              end
`ifdef PAT_SEQ_REPEAT_EN
              rpt_cnt_d = '0;
`endif
            end
`ifdef PAT_SEQ_REPEAT_EN
            OP_RPT: begin
              rpt_cnt_d = offset[RPT_W-1:0];
              pc_d      = pc_inc_c;
            end
`endif
            default: begin
`ifdef PAT_SEQ_REPEAT_EN
              // An armed repeat holds pc on the next instruction.
              if (rpt_cnt_q != '0) rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
              else                 pc_d      = pc_inc_c;
`else
              pc_d = pc_inc_c;
`endif
            end
          endcase
        end
      end
      FAULT: begin
        if (clear_fault && !stall) begin
          state_d      = RUN;
          pc_d         = I_ADR_W'(RESET_PC);
          fault_code_d = FC_NONE;
          clr          = 1'b1;
`ifdef PAT_SEQ_REPEAT_EN
          rpt_cnt_d    = '0;
`endif
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      pc_q         <= I_ADR_W'(RESET_PC);
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_code_q <= fault_code_d;
    end
  end

`ifdef PAT_SEQ_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rpt_cnt_q <= '0;
    else        rpt_cnt_q <= rpt_cnt_d;
  end
`endif

endmodule

// File: tb/tb_pat_seq.sv
// Scoreboard bench for pat_seq with default parameters (I_ADR_W=10, OFF_W=8,
// STACK_DEPTH=8, DEPTH_W=4, RESET_PC=0). Expected values are pushed when a
// cycle's stimulus is driven and popped once the DUT has clocked it.
module tb_pat_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0, op_bf = 1'b0, op_bb = 1'b0, op_call = 1'b0, op_return = 1'b0;
  logic       cond_pass = 1'b0, clear_fault = 1'b0;
  logic [7:0] offset = '0;
  logic [9:0] pc;
  logic [3:0] depth;
  logic       fault;
  logic [1:0] fault_code;
`ifdef PAT_SEQ_REPEAT_EN
  logic       op_repeat = 1'b0;
  logic       rpt_active;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pat_seq dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .op_bf       (op_bf),
    .op_bb       (op_bb),
    .op_call     (op_call),
    .op_return   (op_return),
    .cond_pass   (cond_pass),
    .offset      (offset),
    .clear_fault (clear_fault),
`ifdef PAT_SEQ_REPEAT_EN
    .op_repeat   (op_repeat),
    .rpt_active  (rpt_active),
`endif
    .pc          (pc),
    .depth       (depth),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  // Strobe bits: {bf, bb, call, ret, rpt}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] BF   = 5'b10000;
  localparam logic [4:0] BB   = 5'b01000;
  localparam logic [4:0] CALL = 5'b00100;
  localparam logic [4:0] RET  = 5'b00010;
  localparam logic [4:0] RPT  = 5'b00001;

  typedef struct {
    logic [4:0] ops;
    logic       cp;
    logic       stall;
    logic       clr;
    logic [7:0] off;
    logic [9:0] pc;
    logic [3:0] depth;
    logic       fault;
    logic [1:0] fc;
    logic       ra;
  } row_t;

  row_t sb[$];

  function automatic row_t mk(input logic [4:0] ops, input logic cp, input logic stl,
                              input logic clr, input logic [7:0] off, input logic [9:0] epc,
                              input logic [3:0] edepth, input logic efault,
                              input logic [1:0] efc, input logic era);
    row_t r;
    r.ops = ops; r.cp = cp; r.stall = stl; r.clr = clr; r.off = off;
    r.pc = epc; r.depth = edepth; r.fault = efault; r.fc = efc; r.ra = era;
    return r;
  endfunction

  // Apply one cycle of stimulus, queue its expectation, advance past the edge.
  task automatic drive(input row_t r);
    {op_bf, op_bb, op_call, op_return} = r.ops[4:1];
`ifdef PAT_SEQ_REPEAT_EN
    op_repeat = r.ops[0];
`endif
    cond_pass   = r.cp;
    stall       = r.stall;
    clear_fault = r.clr;
    offset      = r.off;
    sb.push_back(r);
    @(posedge clk);
    #1;
    {op_bf, op_bb, op_call, op_return, cond_pass, stall, clear_fault} = '0;
`ifdef PAT_SEQ_REPEAT_EN
    op_repeat = 1'b0;
`endif
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    reset = 1'b0;
    #2;
    n_tests++;
    if ({pc, depth, fault, fault_code} !== {10'd0, 4'd0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%0d depth=%0d fault=%0b code=%02b, want 0/0/0/00",
               pc, depth, fault, fault_code);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0, 10'(i), 4'd0, 1'b0, 2'b00, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if ({pc, depth, fault, fault_code} !== {e.pc, e.depth, e.fault, e.fc}) begin
        n_fail++;
        $display("FAIL free_run[%0d]: got pc=%0d depth=%0d fault=%0b code=%02b, want pc=%0d depth=%0d fault=%0b code=%02b",
                 i, pc, depth, fault, fault_code, e.pc, e.depth, e.fault, e.fc);
      end
    end
  endtask

  task automatic test_call_return();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(BF,   1'b1, 1'b0, 1'b0, 8'd7, 10'd10, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(CALL, 1'b1, 1'b0, 1'b0, 8'd5, 10'd15, 4'd1, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(RET,  1'b1, 1'b0, 1'b0, 8'd0, 10'd11, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0, 10'd12, 4'd0, 1'b0, 2'b00, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if ({pc, depth, fault, fault_code} !== {e.pc, e.depth, e.fault, e.fc}) begin
        n_fail++;
        $display("FAIL call_return[%0d]: got pc=%0d depth=%0d fault=%0b code=%02b, want pc=%0d depth=%0d fault=%0b code=%02b",
                 i, pc, depth, fault, fault_code, e.pc, e.depth, e.fault, e.fc);
      end
    end
  endtask

  task automatic test_overflow();
    row_t rows[$];
    row_t e;
    // Eight calls of +1 from pc=12 fill the stack; the ninth faults.
    for (int i = 1; i <= 8; i++) rows.push_back(mk(CALL, 1'b1, 1'b0, 1'b0, 8'd1, 10'(12 + i), 4'(i), 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(CALL, 1'b1, 1'b0, 1'b0, 8'd1, 10'd20, 4'd8, 1'b1, 2'b01, 1'b0));
    rows.push_back(mk(BF,   1'b1, 1'b0, 1'b0, 8'd9, 10'd20, 4'd8, 1'b1, 2'b01, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b1, 1'b1, 8'd0, 10'd20, 4'd8, 1'b1, 2'b01, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b1, 8'd0, 10'd0,  4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1,  4'd0, 1'b0, 2'b00, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if ({pc, depth, fault, fault_code} !== {e.pc, e.depth, e.fault, e.fc}) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got pc=%0d depth=%0d fault=%0b code=%02b, want pc=%0d depth=%0d fault=%0b code=%02b",
                 i, pc, depth, fault, fault_code, e.pc, e.depth, e.fault, e.fc);
      end
    end
  endtask

  task automatic test_underflow_wrap();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(RET,  1'b1, 1'b0, 1'b0, 8'd0, 10'd1,    4'd0, 1'b1, 2'b10, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b1, 8'd0, 10'd0,    4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(BB,   1'b1, 1'b0, 1'b0, 8'd1, 10'd1023, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(BF,   1'b1, 1'b0, 1'b0, 8'd2, 10'd1,    4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(BF,   1'b1, 1'b0, 1'b0, 8'd2, 10'd3,    4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(BB,   1'b1, 1'b0, 1'b0, 8'd5, 10'd1022, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(BF,   1'b0, 1'b0, 1'b0, 8'd9, 10'd1023, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0,    4'd0, 1'b0, 2'b00, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if ({pc, depth, fault, fault_code} !== {e.pc, e.depth, e.fault, e.fc}) begin
        n_fail++;
        $display("FAIL underflow_wrap[%0d]: got pc=%0d depth=%0d fault=%0b code=%02b, want pc=%0d depth=%0d fault=%0b code=%02b",
                 i, pc, depth, fault, fault_code, e.pc, e.depth, e.fault, e.fc);
      end
    end
  endtask

  task automatic test_priority_stall();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(BF,        1'b1, 1'b0, 1'b0, 8'd20, 10'd20, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(BF | CALL, 1'b1, 1'b0, 1'b0, 8'd4,  10'd24, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(CALL,      1'b1, 1'b1, 1'b0, 8'd4,  10'd24, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(CALL | RET, 1'b1, 1'b0, 1'b0, 8'd2, 10'd26, 4'd1, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(BB | RET,  1'b1, 1'b0, 1'b0, 8'd1,  10'd25, 4'd1, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(RET,       1'b1, 1'b0, 1'b0, 8'd0,  10'd25, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(CALL,      1'b0, 1'b0, 1'b0, 8'd7,  10'd26, 4'd0, 1'b0, 2'b00, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if ({pc, depth, fault, fault_code} !== {e.pc, e.depth, e.fault, e.fc}) begin
        n_fail++;
        $display("FAIL priority_stall[%0d]: got pc=%0d depth=%0d fault=%0b code=%02b, want pc=%0d depth=%0d fault=%0b code=%02b",
                 i, pc, depth, fault, fault_code, e.pc, e.depth, e.fault, e.fc);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(CALL, 1'b1, 1'b0, 1'b0, 8'd3,  10'd29, 4'd1, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(CALL, 1'b1, 1'b0, 1'b0, 8'd10, 10'd39, 4'd2, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(RET,  1'b1, 1'b0, 1'b0, 8'd0,  10'd30, 4'd1, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(RET,  1'b1, 1'b0, 1'b0, 8'd0,  10'd27, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b1, 8'd0,  10'd28, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(CALL, 1'b1, 1'b0, 1'b0, 8'd2,  10'd30, 4'd1, 1'b0, 2'b00, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if ({pc, depth, fault, fault_code} !== {e.pc, e.depth, e.fault, e.fc}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got pc=%0d depth=%0d fault=%0b code=%02b, want pc=%0d depth=%0d fault=%0b code=%02b",
                 i, pc, depth, fault, fault_code, e.pc, e.depth, e.fault, e.fc);
      end
    end
  endtask

  task automatic test_mid_call_reset();
    row_t e;
    // Call strobe in flight when reset drops asynchronously.
    {op_call, cond_pass} = 2'b11;
    offset = 8'd2;
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({pc, depth, fault, fault_code} !== {10'd0, 4'd0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL mid_call_reset: got pc=%0d depth=%0d fault=%0b code=%02b, want 0/0/0/00",
               pc, depth, fault, fault_code);
    end
    @(negedge clk);
    {op_call, cond_pass} = 2'b00;
    reset = 1'b1;
    drive(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0, 10'd1, 4'd0, 1'b0, 2'b00, 1'b0));
    e = sb.pop_front();
    n_tests++;
    if ({pc, depth, fault, fault_code} !== {e.pc, e.depth, e.fault, e.fc}) begin
      n_fail++;
      $display("FAIL after_reset: got pc=%0d depth=%0d fault=%0b code=%02b, want pc=%0d depth=%0d fault=%0b code=%02b",
               pc, depth, fault, fault_code, e.pc, e.depth, e.fault, e.fc);
    end
  endtask

`ifdef PAT_SEQ_REPEAT_EN
  task automatic test_repeat();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(BF,   1'b1, 1'b0, 1'b0, 8'd39, 10'd40, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(RPT,  1'b1, 1'b0, 1'b0, 8'd3,  10'd41, 4'd0, 1'b0, 2'b00, 1'b1));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0,  10'd41, 4'd0, 1'b0, 2'b00, 1'b1));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0,  10'd41, 4'd0, 1'b0, 2'b00, 1'b1));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0,  10'd41, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0,  10'd42, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(RPT,  1'b1, 1'b0, 1'b0, 8'd5,  10'd43, 4'd0, 1'b0, 2'b00, 1'b1));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0,  10'd43, 4'd0, 1'b0, 2'b00, 1'b1));
    rows.push_back(mk(BF,   1'b1, 1'b0, 1'b0, 8'd2,  10'd45, 4'd0, 1'b0, 2'b00, 1'b0));
    rows.push_back(mk(NONE, 1'b0, 1'b0, 1'b0, 8'd0,  10'd46, 4'd0, 1'b0, 2'b00, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i]);
      e = sb.pop_front();
      n_tests++;
      if ({pc, depth, fault, fault_code, rpt_active} !== {e.pc, e.depth, e.fault, e.fc, e.ra}) begin
        n_fail++;
        $display("FAIL repeat[%0d]: got pc=%0d depth=%0d fault=%0b code=%02b rpt=%0b, want pc=%0d depth=%0d fault=%0b code=%02b rpt=%0b",
                 i, pc, depth, fault, fault_code, rpt_active, e.pc, e.depth, e.fault, e.fc, e.ra);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_call_return();
    test_overflow();
    test_underflow_wrap();
    test_priority_stall();
    test_back_to_back();
    test_mid_call_reset();
`ifdef PAT_SEQ_REPEAT_EN
    test_repeat();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
